image_proc_frame_ctrl: RTL and testbench
========================================

Name: image_proc_frame_ctrl

Overview:
Frame-level sequencer in front of the Bayer-to-RGB / edge-filter datapath. It takes raw sensor timing (frame valid, line valid, pixel data), aligns to a clean frame start and generates pixel X/Y coordinates and a gated data-valid for the datapath. It applies filter-mode changes only on frame boundaries and blanks the line-buffer warm-up rows. It also reports frame count and timing errors to the status/HEX logic.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 960, active lines per frame
WARMUP_LINES, 2, leading lines flagged invalid while the filter line buffers fill
MODE_W, 2, filter-mode select width (bit0 = horizontal/vertical, bit1 = bypass)

Ports:
iCLK  in  1  system clock
iRST  in  1  reset; asynchronous, active-high
iEN  in  1  processing enable (level)
iFVAL  in  1  sensor frame valid
iLVAL  in  1  sensor line valid; one pixel per cycle while high
iDATA  in  12  raw Bayer pixel
iMODE  in  MODE_W  raw switch mode request (asynchronous to iCLK)
oX_Cont  out  11  pixel column of oDATA
oY_Cont  out  11  pixel row of oDATA
oDATA  out  12  registered pixel
oDVAL  out  1  pixel valid to datapath
oMASK  out  1  high while oY_Cont < WARMUP_LINES (downstream forces output black)
oMODE  out  MODE_W  frame-stable filter mode
oFrame_Cont  out  16  completed-frame counter, wraps at 0xFFFF->0
oBUSY  out  1  high in ACTIVE/HBLANK
oERR  out  2  sticky: bit0 short line, bit1 long line/frame

Behaviour:
- Reset (async, iRST=1): state IDLE. All outputs 0, counters 0, mode synchronizer flops 0.
- iMODE passes through a 2-flop synchronizer. Synced value is loaded into oMODE only on the cycle a rising edge of iFVAL is accepted (WAIT_FRAME->ACTIVE). oMODE is constant for the whole frame.
- iFVAL/iLVAL edge detect uses a one-cycle registered copy of each. They are not resynchronized because the sensor is on iCLK.
- States:
  - IDLE: iEN=1 -> SYNC.
  - SYNC: wait for iFVAL=0 so a frame already in progress is discarded. -> WAIT_FRAME.
  - WAIT_FRAME: iFVAL rising -> ACTIVE, with Y=0 and X=0. If iEN=0 -> IDLE.
  - ACTIVE (line in progress): X increments on each cycle with iLVAL=1.
    - iLVAL falling -> HBLANK, Y increments.
    - iFVAL falling -> WAIT_FRAME, oFrame_Cont increments.
  - HBLANK: iLVAL rising -> ACTIVE, X=0. iFVAL falling -> WAIT_FRAME, oFrame_Cont increments.
- iEN deasserted mid-frame: the current frame completes. The transition to IDLE happens at WAIT_FRAME.
- Latency: oDATA/oDVAL/oX_Cont/oY_Cont are registered, 1 cycle after iDATA/iLVAL. The coordinates always describe the pixel on oDATA.
- oDVAL = iLVAL & iFVAL & state ACTIVE & X<H_ACTIVE & Y<V_ACTIVE, registered.
  - Pixels beyond H_ACTIVE in a line: dropped (oDVAL=0), X saturates at H_ACTIVE, oERR[1] set.
  - Lines beyond V_ACTIVE: dropped, Y saturates, oERR[1] set.
- Short line: iLVAL falls with X<H_ACTIVE -> oERR[0] set. The line still counts toward Y. oERR bits clear only on reset.
- oMASK is registered with the same alignment as oY_Cont. It is high for rows 0..WARMUP_LINES-1.
- oBUSY is high in ACTIVE and HBLANK.
- Simultaneous iLVAL fall and iFVAL fall: treated as frame end. Y does not increment, and oFrame_Cont increments once.
- Simultaneous iFVAL rise and iLVAL rise: the first pixel is accepted with X=0, Y=0.
- Reset mid-frame: immediate return to IDLE with outputs 0. After release, SYNC discards the partial frame.

Test Plan:
- Reset then iEN=1 with iFVAL already high mid-frame -> no oDVAL until iFVAL goes low then high. The first oDVAL pixel has oX_Cont=0, oY_Cont=0, 1 cycle after the input.
- Full frame, 4 lines of 1280 pixels, pattern iDATA=(x^y)&FFF, V_ACTIVE=4 -> 5120 oDVAL pulses. oDATA matches the pattern at the coordinates. oMASK is high for rows 0-1 only, oFrame_Cont=1, oERR=0.
- iMODE toggled 0->1 mid-frame -> oMODE stays 0 to frame end and becomes 1 on the next iFVAL rise.
- Line of 1290 pixels -> 1280 oDVAL pulses, oX_Cont holds at 1279, oERR=2'b10. Line of 1000 pixels -> oERR[0]=1 and the next line has oY_Cont incremented.
- iEN dropped at line 2 -> the frame completes and oFrame_Cont increments. Then IDLE, with oBUSY=0 and no oDVAL on the following frame.
- iRST pulsed high at pixel 500 of line 1 -> all outputs 0 asynchronously. The rest of that frame is ignored, and the next frame starts at oY_Cont=0.

Source files
------------

// File: rtl/image_proc_frame_ctrl.sv
// rtl/image_proc_frame_ctrl.sv - frame sequencer: sensor timing alignment, pixel coordinates, frame-stable mode
// Gates sensor pixels into the Bayer/edge datapath and reports frame count and timing errors.
module image_proc_frame_ctrl #(
  parameter int H_ACTIVE     = 1280,
  parameter int V_ACTIVE     = 960,
  parameter int WARMUP_LINES = 2,
  parameter int MODE_W       = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic [11:0]       iDATA,
  input  logic [MODE_W-1:0] iMODE,
  output logic [10:0]       oX_Cont,
  output logic [10:0]       oY_Cont,
  output logic [11:0]       oDATA,
  output logic              oDVAL,
  output logic              oMASK,
  output logic [MODE_W-1:0] oMODE,
  output logic [15:0]       oFrame_Cont,
  output logic              oBUSY,
  output logic [1:0]        oERR
);

  typedef enum logic [2:0] {IDLE, SYNC, WAIT_FRAME, ACTIVE, HBLANK} state_t;

  localparam logic [10:0] H_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_END  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] WARM   = 11'(WARMUP_LINES);

  state_t            state;
  logic              fvalD, lvalD;
  logic [MODE_W-1:0] modeMeta, modeSync;
  logic [10:0]       xCnt, yCnt;

  logic fvalRise, fvalFall, lvalRise, lvalFall;
  assign fvalRise = iFVAL & ~fvalD;
  assign fvalFall = ~iFVAL & fvalD;
  assign lvalRise = iLVAL & ~lvalD;
  assign lvalFall = ~iLVAL & lvalD;

  assign oBUSY = (state == ACTIVE) || (state == HBLANK);

  // Coordinates of the pixel present on iDATA this cycle; line/frame starts force X (and Y) to 0.
  logic        pixTake, pixInRange;
  logic [10:0] pixX, pixY;
  always_comb begin
    pixTake = 1'b0;
    pixX    = xCnt;
    pixY    = yCnt;
    case (state)
      WAIT_FRAME: if (iEN && fvalRise && iLVAL) begin
        pixTake = 1'b1;
        pixX    = '0;
        pixY    = '0;
      end
      ACTIVE: pixTake = !fvalFall && iLVAL;
      HBLANK: if (!fvalFall && lvalRise) begin
        pixTake = 1'b1;
        pixX    = '0;
      end
      default: ;
    endcase
    pixInRange = (pixX < H_END) && (pixY < V_END);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      fvalD       <= 1'b0;
      lvalD       <= 1'b0;
      modeMeta    <= '0;
      modeSync    <= '0;
      xCnt        <= '0;
      yCnt        <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oMASK       <= 1'b0;
      oMODE       <= '0;
      oFrame_Cont <= '0;
      oERR        <= '0;
    end else begin
      fvalD    <= iFVAL;
      lvalD    <= iLVAL;
      modeMeta <= iMODE;
      modeSync <= modeMeta;
      oDVAL    <= pixTake & iFVAL & pixInRange;

      case (state)
        IDLE:       if (iEN) state <= SYNC;
        SYNC:       if (!iFVAL) state <= WAIT_FRAME;
        WAIT_FRAME: begin
          if (!iEN) begin
            state <= IDLE;
          end else if (fvalRise) begin
            state <= ACTIVE;
            oMODE <= modeSync;
            xCnt  <= '0;
            yCnt  <= '0;
          end
        end
        ACTIVE: begin
          // Frame end wins over a coincident line end: no extra row is counted.
          if (fvalFall) begin
            state       <= WAIT_FRAME;
            oFrame_Cont <= oFrame_Cont + 16'd1;
          end else if (lvalFall) begin
            state <= HBLANK;
            yCnt  <= (yCnt < V_END) ? yCnt + 11'd1 : V_END;
            if (xCnt < H_END) oERR[0] <= 1'b1;
          end
        end
        HBLANK: begin
          if (fvalFall) begin
            state       <= WAIT_FRAME;
            oFrame_Cont <= oFrame_Cont + 16'd1;
          end else if (lvalRise) begin
            state <= ACTIVE;
            xCnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (pixTake) begin
        oDATA   <= iDATA;
        oX_Cont <= (pixX < H_END) ? pixX : H_LAST;
        oY_Cont <= (pixY < V_END) ? pixY : V_LAST;
        oMASK   <= pixY < WARM;
        xCnt    <= (pixX < H_END) ? pixX + 11'd1 : H_END;
        if (!pixInRange) oERR[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_proc_frame_ctrl.sv
// tb/tb_image_proc_frame_ctrl.sv - directed/randomized bench for image_proc_frame_ctrl
module tb_image_proc_frame_ctrl;

  localparam int H = 1280;
  localparam int V = 4;
  localparam int WARM = 2;

  logic        iCLK = 1'b0;
  logic        iRST, iEN, iFVAL, iLVAL;
  logic [11:0] iDATA;
  logic [1:0]  iMODE;
  logic [10:0] oX_Cont, oY_Cont;
  logic [11:0] oDATA;
  logic        oDVAL, oMASK, oBUSY;
  logic [1:0]  oMODE, oERR;
  logic [15:0] oFrame_Cont;

  image_proc_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .WARMUP_LINES(WARM), .MODE_W(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDATA(iDATA),
    .iMODE(iMODE), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oDATA(oDATA), .oDVAL(oDVAL),
    .oMASK(oMASK), .oMODE(oMODE), .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int          total = 0;
  int          bad = 0;
  logic [34:0] obsQ[$];
  logic [34:0] expQ[$];
  int          lens[0:7];
  int          lineEndX[0:7];
  int          modeChgLine = -1, enDropLine = -1, rstLine = -1, rstPix = -1;
  logic [1:0]  modeNew = 2'd0;
  logic [1:0]  midMode;
  logic        busyMid;
  logic [22:0] firstSample;
  int          frameExp = 0;
  logic [1:0]  errExp = 2'b00;

  always @(negedge iCLK)
    if (oDVAL === 1'b1) obsQ.push_back({oX_Cont, oY_Cont, oDATA, oMASK});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic doReset();
    iRST = 1'b1;
    #1;
    chk("reset_async_outputs",
        {oX_Cont, oY_Cont, oDATA, oDVAL, oMASK, oMODE, oFrame_Cont, oBUSY, oERR}, 64'd0);
    step();
    iRST = 1'b0;
    obsQ.delete();
    frameExp = 0;
    errExp   = 2'b00;
  endtask

  // Drives one sensor frame; when accept is set the reference expectations are appended.
  task automatic driveFrame(input int nLines, input bit simul, input bit accept, input logic [11:0] seed);
    int gap;
    iFVAL = 1'b1;
    if (!simul) repeat ($urandom_range(1, 3)) step();
    for (int l = 0; l < nLines; l++) begin
      if (l == modeChgLine) iMODE = modeNew;
      if (l == enDropLine) iEN = 1'b0;
      if (l == 1) begin
        midMode = oMODE;
        busyMid = oBUSY;
      end
      iLVAL = 1'b1;
      for (int p = 0; p < lens[l]; p++) begin
        if (l == 0 && p == 1) firstSample = {oDVAL, oX_Cont, oY_Cont};
        iDATA = 12'(p ^ l) ^ seed;
        if (accept && p < H && l < V)
          expQ.push_back({11'(p), 11'(l), 12'(p ^ l) ^ seed, (l < WARM) ? 1'b1 : 1'b0});
        if (l == rstLine && p == rstPix) doReset();
        step();
      end
      if (accept && (lens[l] > H || (l >= V && lens[l] > 0))) errExp[1] = 1'b1;
      if (l == nLines - 1 && simul) begin
        iLVAL = 1'b0;
        iFVAL = 1'b0;
      end else begin
        iLVAL = 1'b0;
        if (accept && lens[l] < H) errExp[0] = 1'b1;
        gap = $urandom_range(2, 5);
        repeat (gap) step();
        lineEndX[l] = int'(oX_Cont);
      end
    end
    iFVAL = 1'b0;
    repeat ($urandom_range(4, 8)) step();
    if (accept) frameExp++;
  endtask

  task automatic checkFrame(input string tag);
    int n, idx;
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    chk({tag, "_pixel_count"}, obsQ.size(), expQ.size());
    idx = 0;
    for (int i = 0; i < n; i++)
      if (obsQ[i] !== expQ[i]) begin
        idx = i;
        break;
      end
    if (n > 0) chk({tag, "_pixel_xy_data_mask"}, obsQ[idx], expQ[idx]);
    chk({tag, "_frame_count"}, oFrame_Cont, 16'(frameExp));
    chk({tag, "_err"}, oERR, errExp);
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic setLens(input int n, input int len);
    for (int i = 0; i < 8; i++) lens[i] = (i < n) ? len : 0;
  endtask

  initial begin
    iRST = 1'b1; iEN = 1'b0; iFVAL = 1'b1; iLVAL = 1'b0; iDATA = '0; iMODE = 2'd0;
    repeat (3) step();
    chk("reset_state_outputs",
        {oX_Cont, oY_Cont, oDATA, oDVAL, oMASK, oMODE, oFrame_Cont, oBUSY, oERR}, 64'd0);

    // Frame already in progress when enabled: discarded.
    iRST = 1'b0;
    iEN  = 1'b1;
    setLens(2, H);
    driveFrame(2, 1'b0, 1'b0, 12'h000);
    checkFrame("partial_ignored");

    // Reference pattern frame with a mode change on line 2.
    setLens(4, H);
    modeChgLine = 2; modeNew = 2'd1;
    driveFrame(4, 1'b0, 1'b1, 12'h000);
    modeChgLine = -1;
    chk("first_pixel_latency", firstSample, {1'b1, 11'd0, 11'd0});
    chk("mode_during_frame", midMode, 2'd0);
    chk("mode_held_after_frame", oMODE, 2'd0);
    checkFrame("pattern");

    // Simultaneous edges at frame start and end, random data and short final line.
    setLens($urandom_range(3, 4), H);
    if (lens[3] == H) lens[3] = $urandom_range(1200, H); else lens[2] = $urandom_range(1200, H);
    driveFrame(lens[3] == 0 ? 3 : 4, 1'b1, 1'b1, 12'($urandom));
    chk("mode_after_next_rise", midMode, 2'd1);
    checkFrame("simul_edges");

    // Over-long line plus an extra line beyond V_ACTIVE.
    setLens(5, H);
    lens[1] = H + 10;
    driveFrame(5, 1'b0, 1'b1, 12'($urandom));
    chk("long_line_x_hold", lineEndX[1], H - 1);
    checkFrame("long");

    // Short line still advances Y.
    setLens(4, H);
    lens[1] = 1000;
    driveFrame(4, 1'b0, 1'b1, 12'($urandom));
    checkFrame("short");

    // Enable dropped mid-frame: frame completes, then idle.
    enDropLine = 2;
    driveFrame(4, 1'b0, 1'b1, 12'($urandom));
    enDropLine = -1;
    chk("busy_after_disable", oBUSY, 1'b0);
    checkFrame("en_drop");
    setLens(2, H);
    driveFrame(2, 1'b0, 1'b0, 12'($urandom));
    chk("busy_while_idle", busyMid, 1'b0);
    checkFrame("disabled_frame");

    iEN = 1'b1;
    repeat (3) step();
    setLens(4, H);
    driveFrame(4, 1'b0, 1'b1, 12'($urandom));
    checkFrame("reenabled");

    // Reset at pixel 500 of line 1: rest of frame ignored.
    setLens(3, H);
    rstLine = 1; rstPix = 500;
    driveFrame(3, 1'b0, 1'b0, 12'($urandom));
    rstLine = -1; rstPix = -1;
    chk("mode_after_reset", oMODE, 2'd0);
    checkFrame("reset_frame");

    setLens(4, H);
    driveFrame(4, 1'b0, 1'b1, 12'($urandom));
    checkFrame("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
